// File: rtl/upsizer.sv
// upsizer
//   Packs a stream of narrow input beats into wide output words. The first
//   accepted beat of a word lands in lane 0, the next in lane 1, and so on.
//   A word is emitted when every lane is filled, or earlier when last_in
//   closes it. Lanes that were never written read as zero, and their keep
//   bits are clear.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset; any partial word is dropped
//   inp_data   narrow input beat (INP_DATA_WIDTH bytes)
//   valid_in   inp_data / last_in are valid
//   last_in    this beat ends a packet; close the word after it
//   ready      a beat is accepted this cycle when valid_in is also high
//   data_out   packed word; lane k = bits [(k+1)*LANE_BITS-1 : k*LANE_BITS]
//   out_keep   bit k set when lane k holds valid data
//   out_last   the word was closed by last_in
//   out_en     data_out / out_keep / out_last are valid
//   out_ready  downstream accepts the word this cycle
module upsizer #(
  parameter int INP_DATA_WIDTH = 32,
  parameter int DATA_OUT_WIDTH = 128,
  parameter int BEAT_CNT_WIDTH = $clog2(DATA_OUT_WIDTH / INP_DATA_WIDTH)
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic [INP_DATA_WIDTH*8-1:0]                inp_data,
  input  logic                                       valid_in,
  input  logic                                       last_in,
  output logic                                       ready,
  output logic [DATA_OUT_WIDTH*8-1:0]                data_out,
  output logic [DATA_OUT_WIDTH/INP_DATA_WIDTH-1:0]   out_keep,
  output logic                                       out_last,
  output logic                                       out_en,
  input  logic                                       out_ready
);

  localparam int RATIO     = DATA_OUT_WIDTH / INP_DATA_WIDTH;
  localparam int LANE_BITS = INP_DATA_WIDTH * 8;
  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_LANE = BEAT_CNT_WIDTH'(RATIO - 1);

  logic [BEAT_CNT_WIDTH-1:0]   cnt_q,  cnt_d;
  logic [DATA_OUT_WIDTH*8-1:0] data_q, data_d;
  logic [RATIO-1:0]            keep_q, keep_d;
  logic                        last_q, last_d;
  logic                        en_q,   en_d;

  logic slot_free;
  logic beat_accept;
  logic word_taken;

  // The word register is free when nothing is held, or when the held word
  // leaves this very cycle; that is what gives back-to-back throughput.
  assign slot_free   = !en_q || out_ready;
  assign beat_accept = valid_in && slot_free;
  assign word_taken  = en_q && out_ready;

  // State register. out_en doubles as the FILL/HOLD state bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      keep_q <= keep_d;
      last_q <= last_d;
      en_q   <= en_d;
    end
  end

  // Next-state logic. A consumed word is cleared first, so a beat accepted
  // in the same cycle starts a fresh word in lane 0 (cnt_q is always 0
  // while a word is held).
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    en_d   = en_q;

    if (word_taken) begin
      en_d   = 1'b0;
      data_d = '0;
      keep_d = '0;
      last_d = 1'b0;
      cnt_d  = '0;
    end

    if (beat_accept) begin
      for (int k = 0; k < RATIO; k++) begin
        if (cnt_q == BEAT_CNT_WIDTH'(k)) begin
          data_d[k*LANE_BITS +: LANE_BITS] = inp_data;
          keep_d[k]                        = 1'b1;
        end
      end

      if (cnt_q == LAST_LANE || last_in) begin
        en_d   = 1'b1;
        last_d = last_in;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + BEAT_CNT_WIDTH'(1);
      end
    end
  end

  // Outputs. Everything but ready comes straight from registers.
  always_comb begin
    ready    = slot_free;
    data_out = data_q;
    out_keep = keep_q;
    out_last = last_q;
    out_en   = en_q;
  end

endmodule

// File: tb/tb_upsizer.sv
// tb_upsizer
//   Scoreboard bench for upsizer with default parameters (4 lanes of 32 bytes).
//   The driver issues beats; a negedge monitor keeps a reference model (a list
//   of pending beats and a queue of expected words), predicts out_en/ready and
//   compares every held word against the head of the expected queue.
module tb_upsizer;

  localparam int IN_B  = 32;
  localparam int OUT_B = 128;
  localparam int RATIO = OUT_B / IN_B;
  localparam int IW    = IN_B * 8;
  localparam int OW    = OUT_B * 8;

  typedef struct {
    logic [OW-1:0]    data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  logic             clk;
  logic             rstn;
  logic [IW-1:0]    inp_data;
  logic             valid_in;
  logic             last_in;
  logic             ready;
  logic [OW-1:0]    data_out;
  logic [RATIO-1:0] out_keep;
  logic             out_last;
  logic             out_en;
  logic             out_ready;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;
  bit timeout_flag = 0;
  bit timeout_seen = 0;
  bit end_check = 0;
  bit end_done = 0;

  logic [IW-1:0] part_q[$];
  word_t         exp_q[$];

  upsizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .inp_data  (inp_data),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .ready     (ready),
    .data_out  (data_out),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_en    (out_en),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] fill(input logic [7:0] b);
    fill = {IN_B{b}};
  endfunction

  function automatic logic [IW-1:0] rand_beat();
    logic [IW-1:0] v;
    for (int i = 0; i < IW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic void chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: beats accumulate in part_q; a word is closed when
  // RATIO beats are collected or a beat carries last.
  function automatic void model_beat(input logic [IW-1:0] d, input logic l);
    word_t w;
    part_q.push_back(d);
    if (part_q.size() == RATIO || l) begin
      w.data = '0;
      w.keep = '0;
      w.last = l;
      for (int i = 0; i < part_q.size(); i++) begin
        w.data[i*IW +: IW] = part_q[i];
        w.keep[i]          = 1'b1;
      end
      exp_q.push_back(w);
      part_q.delete();
    end
  endfunction

  always @(negedge clk) begin
    bit exp_en;
    if (!rstn) begin
      chk("reset out_en",   IW'(out_en),   '0);
      chk("reset out_keep", IW'(out_keep), '0);
      chk("reset out_last", IW'(out_last), '0);
      chk("reset data_out", IW'(|data_out), '0);
      part_q.delete();
      exp_q.delete();
    end else begin
      exp_en = (exp_q.size() > 0);
      chk("out_en", IW'(out_en), IW'(exp_en));
      chk("ready",  IW'(ready),  IW'(!exp_en || out_ready));
      if (exp_en && out_en) begin
        for (int k = 0; k < RATIO; k++)
          chk($sformatf("data lane %0d", k), data_out[k*IW +: IW], exp_q[0].data[k*IW +: IW]);
        chk("out_keep", IW'(out_keep), IW'(exp_q[0].keep));
        chk("out_last", IW'(out_last), IW'(exp_q[0].last));
      end
      if (exp_en && out_ready) void'(exp_q.pop_front());
      if (valid_in && (!exp_en || out_ready)) model_beat(inp_data, last_in);
    end

    if (timeout_flag && !timeout_seen) begin
      timeout_seen = 1;
      checks++;
      errors++;
      $display("[TB] FAIL handshake timeout: beat not accepted within budget at %0t", $time);
    end
    if (end_check && !end_done) begin
      end_done = 1;
      chk("drain words", IW'(exp_q.size()),  '0);
      chk("drain beats", IW'(part_q.size()), '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(0, 99) < ready_pct);
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic l, input int gap);
    bit done;
    valid_in = 1'b0;
    repeat (gap) tick();
    valid_in = 1'b1;
    inp_data = d;
    last_in  = l;
    done     = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ready) done = 1;
      tick();
    end
    if (!done) timeout_flag = 1;
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic apply_stimulus();
    // Full word, back to back.
    ready_pct = 100;
    for (int i = 1; i <= 4; i++) send_beat(fill(8'(i * 8'h11)), 1'b0, 0);
    idle(3);

    // Partial word closed by last.
    send_beat(fill(8'hAA), 1'b0, 0);
    send_beat(fill(8'hBB), 1'b1, 0);
    idle(3);

    // Backpressure: word held for 5 cycles while the next beat waits.
    ready_pct = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(fill(8'(8'h50 + i)), 1'b0, 0);
    valid_in = 1'b1;
    inp_data = fill(8'h5A);
    last_in  = 1'b0;
    repeat (5) tick();
    ready_pct = 100;
    out_ready = 1'b1;
    valid_in  = 1'b0;
    send_beat(fill(8'h5A), 1'b0, 0);
    for (int i = 0; i < 3; i++) send_beat(fill(8'(8'h60 + i)), 1'b0, 0);
    idle(3);

    // Streaming: 12 beats -> 3 words.
    for (int i = 0; i < 12; i++) send_beat(fill(8'(8'hC0 + i)), 1'b0, 0);
    idle(3);

    // Reset mid-fill.
    send_beat(fill(8'hE1), 1'b0, 0);
    send_beat(fill(8'hE2), 1'b0, 0);
    rstn = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(fill(8'(8'hF0 + i)), 1'b0, 0);
    idle(3);

    // Idle gaps between beats.
    for (int i = 1; i <= 4; i++) send_beat(fill(8'(i * 8'h11)), 1'b0, 3);
    idle(3);

    // Randomized traffic with random backpressure and gaps.
    ready_pct = 70;
    for (int i = 0; i < 300; i++)
      send_beat(rand_beat(), ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    ready_pct = 100;
    idle(6);
  endtask

  initial begin
    rstn      = 1'b0;
    inp_data  = '0;
    valid_in  = 1'b0;
    last_in   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    apply_stimulus();
    end_check = 1;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
